sync_stage_fifo: RTL and testbench

//   Single-clock, parametrised multi-entry staging buffer; next generation of the one-entry hold register.

---
 rtl/sync_stage_fifo.sv | 153 +++++++++++++++
 tb/tb_sync_stage_fifo.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/sync_stage_fifo.sv
// sync_stage_fifo: single-clock multi-entry staging buffer with
// first-word-fall-through read data, occupancy/status flags, optional
// overwrite-oldest mode and sticky overflow/underflow error flags.
// Every output comes straight from a flop; the next-state logic is computed
// once in a combinational block and registered on the rising edge.
`timescale 1ns/1ps

module sync_stage_fifo #(
  parameter int SIZE      = 4,
  parameter int DEPTH     = 4,
  parameter int AF_LEVEL  = 3,
  parameter bit OVERWRITE = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [SIZE-1:0]            w_data,
  input  logic                       w_en,
  input  logic                       r_en,
  input  logic                       clr_err,
  output logic [SIZE-1:0]            r_data,
  output logic                       r_empty,
  output logic                       w_full,
  output logic                       almost_full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(AF_LEVEL);

  // Storage array; deliberately not reset so it maps onto plain RAM.
  logic [SIZE-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [SIZE-1:0]  r_data_q, r_data_d;
  logic             r_empty_q, r_empty_d;
  logic             w_full_q, w_full_d;
  logic             almost_full_q, almost_full_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic             is_full;
  logic             is_empty;
  logic             push_ok;
  logic             pop_ok;
  logic             ovw_ok;
  logic             mem_we;

  // Pointer increment that wraps from DEPTH-1 back to 0, so DEPTH need not
  // be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Next-state decode: accept/reject push and pop, advance pointers, update
  // occupancy, and precompute every registered output from the new state.
  always_comb begin
    is_full  = (count_q == CNT_FULL);
    is_empty = (count_q == '0);

    // A push into a full buffer is still accepted when a pop frees a slot
    // in the same cycle.
    push_ok = w_en && (!is_full || r_en);
    pop_ok  = r_en && !is_empty;
    // Overwrite-oldest: full, push, no pop; the write lands and the oldest
    // word is discarded by moving the read pointer along with it.
    ovw_ok  = OVERWRITE && w_en && is_full && !r_en;
    mem_we  = (push_ok || ovw_ok) && !rst;

    wr_ptr_d = (push_ok || ovw_ok) ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = (pop_ok  || ovw_ok) ? ptr_inc(rd_ptr_q) : rd_ptr_q;

    count_d = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - CNT_W'(1);
    end

    r_empty_d     = (count_d == '0);
    w_full_d      = (count_d == CNT_FULL);
    almost_full_d = (count_d >= CNT_AF);

    // Head word for the next cycle. If the slot about to become the head is
    // the one being written right now, the array still holds stale data, so
    // forward the incoming word instead.
    if (count_d == '0) begin
      r_data_d = '0;
    end else if ((push_ok || ovw_ok) && (wr_ptr_q == rd_ptr_d)) begin
      r_data_d = w_data;
    end else begin
      r_data_d = mem_q[rd_ptr_d];
    end

    // Sticky errors: clear first, then let a same-cycle event set them again.
    overflow_d  = clr_err ? 1'b0 : overflow_q;
    underflow_d = clr_err ? 1'b0 : underflow_q;
    if (w_en && is_full && !r_en) begin
      overflow_d = 1'b1;
    end
    if (r_en && is_empty) begin
      underflow_d = 1'b1;
    end
  end

  // Storage write port; reset suppresses the write through mem_we.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wr_ptr_q] <= w_data;
    end
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      r_data_q      <= '0;
      r_empty_q     <= 1'b1;
      w_full_q      <= 1'b0;
      almost_full_q <= 1'b0;
      overflow_q    <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      r_data_q      <= r_data_d;
      r_empty_q     <= r_empty_d;
      w_full_q      <= w_full_d;
      almost_full_q <= almost_full_d;
      overflow_q    <= overflow_d;
      underflow_q   <= underflow_d;
    end
  end

  assign r_data      = r_data_q;
  assign r_empty     = r_empty_q;
  assign w_full      = w_full_q;
  assign almost_full = almost_full_q;
  assign count       = count_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;

endmodule

// File: tb/tb_sync_stage_fifo.sv
// Testbench for sync_stage_fifo: two instances (drop mode and overwrite mode)
// share one stimulus stream. Expected pop data is queued per instance when a
// pop is issued; a negedge monitor pops and compares whenever a pop is
// actually presented to a non-empty DUT. Status flags are checked directly.
`timescale 1ns/1ps

module tb_sync_stage_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       w_en;
  logic       r_en;
  logic       clr_err;
  logic [3:0] w_data;

  logic [3:0] d0_rdata, d1_rdata;
  logic       d0_empty, d1_empty;
  logic       d0_full, d1_full;
  logic       d0_af, d1_af;
  logic [2:0] d0_count, d1_count;
  logic       d0_ovf, d1_ovf;
  logic       d0_unf, d1_unf;

  int checks = 0;
  int errors = 0;

  logic [3:0] q0[$];
  logic [3:0] q1[$];

  always #5 clk = ~clk;

  sync_stage_fifo #(.SIZE(4), .DEPTH(4), .AF_LEVEL(3), .OVERWRITE(1'b0)) dut0 (
    .clk(clk), .rst(rst), .w_data(w_data), .w_en(w_en), .r_en(r_en),
    .clr_err(clr_err), .r_data(d0_rdata), .r_empty(d0_empty), .w_full(d0_full),
    .almost_full(d0_af), .count(d0_count), .overflow(d0_ovf), .underflow(d0_unf)
  );

  sync_stage_fifo #(.SIZE(4), .DEPTH(4), .AF_LEVEL(3), .OVERWRITE(1'b1)) dut1 (
    .clk(clk), .rst(rst), .w_data(w_data), .w_en(w_en), .r_en(r_en),
    .clr_err(clr_err), .r_data(d1_rdata), .r_empty(d1_empty), .w_full(d1_full),
    .almost_full(d1_af), .count(d1_count), .overflow(d1_ovf), .underflow(d1_unf)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: a pop presented to a non-empty DUT consumes one expected word.
  always @(negedge clk) begin
    if (!rst && r_en) begin
      if (!d0_empty) begin
        if (q0.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL dut0 pop: got data=%0d expected no pop", d0_rdata);
        end else begin
          $display("pop dut0 data=%0d expected=%0d", d0_rdata, q0[0]);
          check("dut0 pop data", int'(d0_rdata), int'(q0.pop_front()));
        end
      end
      if (!d1_empty) begin
        if (q1.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL dut1 pop: got data=%0d expected no pop", d1_rdata);
        end else begin
          $display("pop dut1 data=%0d expected=%0d", d1_rdata, q1[0]);
          check("dut1 pop data", int'(d1_rdata), int'(q1.pop_front()));
        end
      end
    end
  end

  // One clock edge with the given inputs; inputs return to idle afterwards.
  task automatic step(input bit we, input int wd, input bit re, input bit clr);
    w_en    = we;
    w_data  = 4'(wd);
    r_en    = re;
    clr_err = clr;
    @(posedge clk);
    #1;
    w_en    = 1'b0;
    r_en    = 1'b0;
    clr_err = 1'b0;
  endtask

  // Status expected identically on both instances.
  task automatic st(input string tag, input int cnt, input bit emp, input bit full,
                    input bit af, input bit ovf, input bit unf);
    check({tag, " dut0 count"}, int'(d0_count), cnt);
    check({tag, " dut0 r_empty"}, int'(d0_empty), int'(emp));
    check({tag, " dut0 w_full"}, int'(d0_full), int'(full));
    check({tag, " dut0 almost_full"}, int'(d0_af), int'(af));
    check({tag, " dut0 overflow"}, int'(d0_ovf), int'(ovf));
    check({tag, " dut0 underflow"}, int'(d0_unf), int'(unf));
    check({tag, " dut1 count"}, int'(d1_count), cnt);
    check({tag, " dut1 r_empty"}, int'(d1_empty), int'(emp));
    check({tag, " dut1 w_full"}, int'(d1_full), int'(full));
    check({tag, " dut1 almost_full"}, int'(d1_af), int'(af));
    check({tag, " dut1 overflow"}, int'(d1_ovf), int'(ovf));
    check({tag, " dut1 underflow"}, int'(d1_unf), int'(unf));
    $display("status %s: count=%0d/%0d empty=%0d/%0d full=%0d/%0d", tag,
             d0_count, d1_count, d0_empty, d1_empty, d0_full, d1_full);
  endtask

  task automatic rd(input string tag, input int e0, input int e1);
    check({tag, " dut0 r_data"}, int'(d0_rdata), e0);
    check({tag, " dut1 r_data"}, int'(d1_rdata), e1);
  endtask

  task automatic expect_pop(input int v0, input int v1);
    q0.push_back(4'(v0));
    q1.push_back(4'(v1));
  endtask

  initial begin
    // Reset held two edges with push and pop both requested.
    rst     = 1'b1;
    w_en    = 1'b1;
    r_en    = 1'b1;
    clr_err = 1'b0;
    w_data  = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    rst  = 1'b0;
    w_en = 1'b0;
    r_en = 1'b0;
    st("reset", 0, 1, 0, 0, 0, 0);
    rd("reset", 0, 0);

    // Fill 1..4 then drain.
    step(1, 1, 0, 0); st("fill1", 1, 0, 0, 0, 0, 0); rd("fill1", 1, 1);
    step(1, 2, 0, 0); st("fill2", 2, 0, 0, 0, 0, 0);
    step(1, 3, 0, 0); st("fill3", 3, 0, 0, 1, 0, 0);
    step(1, 4, 0, 0); st("fill4", 4, 0, 1, 1, 0, 0); rd("fill4", 1, 1);
    for (int v = 1; v <= 4; v++) expect_pop(v, v);
    repeat (4) step(0, 0, 1, 0);
    st("drain", 0, 1, 0, 0, 0, 0); rd("drain", 0, 0);

    // Wrap: pointers move to 3, then A..D straddle the 3->0 boundary.
    for (int v = 1; v <= 3; v++) step(1, v, 0, 0);
    for (int v = 1; v <= 3; v++) expect_pop(v, v);
    repeat (3) step(0, 0, 1, 0);
    for (int v = 10; v <= 13; v++) step(1, v, 0, 0);
    st("wrap full", 4, 0, 1, 1, 0, 0); rd("wrap full", 10, 10);
    for (int v = 10; v <= 13; v++) expect_pop(v, v);
    repeat (4) step(0, 0, 1, 0);
    st("wrap drain", 0, 1, 0, 0, 0, 0);

    // Overflow: drop mode keeps 1..4, overwrite mode discards the oldest.
    for (int v = 1; v <= 4; v++) step(1, v, 0, 0);
    step(1, 9, 0, 0);
    st("ovf", 4, 0, 1, 1, 1, 0); rd("ovf", 1, 2);
    // Second overflow together with clr_err: the new event wins.
    step(1, 9, 0, 1);
    st("ovf clr race", 4, 0, 1, 1, 1, 0); rd("ovf clr race", 1, 3);
    expect_pop(1, 3); expect_pop(2, 4); expect_pop(3, 9); expect_pop(4, 9);
    repeat (4) step(0, 0, 1, 0);
    st("ovf drain", 0, 1, 0, 0, 1, 0);
    step(0, 0, 0, 1);
    st("ovf clr", 0, 1, 0, 0, 0, 0);

    // Empty + push + pop: push taken, pop ignored, underflow set.
    step(1, 5, 1, 0);
    st("empty push pop", 1, 0, 0, 0, 0, 1); rd("empty push pop", 5, 5);
    step(0, 0, 0, 1);
    st("unf clr", 1, 0, 0, 0, 0, 0);

    // Full + push + pop: both accepted, no overflow.
    step(1, 6, 0, 0); step(1, 8, 0, 0); step(1, 10, 0, 0);
    st("full again", 4, 0, 1, 1, 0, 0);
    expect_pop(5, 5);
    step(1, 7, 1, 0);
    st("full push pop", 4, 0, 1, 1, 0, 0); rd("full push pop", 6, 6);
    expect_pop(6, 6); expect_pop(8, 8); expect_pop(10, 10); expect_pop(7, 7);
    repeat (4) step(0, 0, 1, 0);
    st("full pp drain", 0, 1, 0, 0, 0, 0); rd("full pp drain", 0, 0);

    // Pop while empty; then pop with clr_err (event wins); then clear.
    step(0, 0, 1, 0);
    st("pop empty", 0, 1, 0, 0, 0, 1);
    step(0, 0, 1, 1);
    st("unf clr race", 0, 1, 0, 0, 0, 1);
    step(0, 0, 0, 1);
    st("unf clr2", 0, 1, 0, 0, 0, 0);

    // Reset with count=3 while push/pop requested.
    for (int v = 1; v <= 3; v++) step(1, v, 0, 0);
    st("pre reset", 3, 0, 0, 1, 0, 0);
    rst = 1'b1;
    step(1, 12, 1, 0);
    rst = 1'b0;
    st("mid reset", 0, 1, 0, 0, 0, 0); rd("mid reset", 0, 0);

    // Buffer usable after reset.
    step(1, 6, 0, 0);
    st("post reset", 1, 0, 0, 0, 0, 0); rd("post reset", 6, 6);
    expect_pop(6, 6);
    step(0, 0, 1, 0);
    st("post reset drain", 0, 1, 0, 0, 0, 0);

    check("dut0 scoreboard drained", q0.size(), 0);
    check("dut1 scoreboard drained", q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
